// File: rtl/nbdcache_tl_pkg.sv
// rtl/nbdcache_tl_pkg.sv - TileLink grant widths, grant type encodings and type decode helpers.
package nbdcache_tl_pkg;

    localparam int DATA_W  = 128;
    localparam int BEATS   = 4;
    localparam int CXID_W  = 2;
    localparam int MXID_W  = 4;
    localparam int GTYPE_W = 4;
    localparam int BEAT_W  = $clog2(BEATS);

    localparam logic [GTYPE_W-1:0] GNT_SHARED   = 4'd0;
    localparam logic [GTYPE_W-1:0] GNT_EXCL     = 4'd1;
    localparam logic [GTYPE_W-1:0] GNT_EXCL_ACK = 4'd2;
    localparam logic [GTYPE_W-1:0] BI_GET_BEAT  = 4'd3;
    localparam logic [GTYPE_W-1:0] BI_GET_BLOCK = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    function automatic logic has_data(input logic builtin, input logic [GTYPE_W-1:0] g_type);
        if (builtin)
            return (g_type == BI_GET_BEAT) || (g_type == BI_GET_BLOCK);
        else
            return (g_type == GNT_SHARED) || (g_type == GNT_EXCL);
    endfunction

    function automatic logic multibeat(input logic builtin, input logic [GTYPE_W-1:0] g_type);
        return has_data(builtin, g_type) && !(builtin && (g_type == BI_GET_BEAT));
    endfunction

    function automatic logic needs_finish(input logic builtin);
        return !builtin;
    endfunction

endpackage

// File: rtl/grant_refill_collector_if.sv
// rtl/grant_refill_collector_if.sv - grant in, refill write, finish and status signals of the collector.
interface grant_refill_collector_if
    import nbdcache_tl_pkg::*;
#(
    parameter int P_DATA_W  = DATA_W,
    parameter int P_BEAT_W  = BEAT_W,
    parameter int P_CXID_W  = CXID_W,
    parameter int P_MXID_W  = MXID_W,
    parameter int P_GTYPE_W = GTYPE_W
) ();

    logic                  io_in_valid;
    logic                  io_in_ready;
    logic [P_BEAT_W-1:0]   io_in_bits_addr_beat;
    logic [P_CXID_W-1:0]   io_in_bits_client_xact_id;
    logic [P_MXID_W-1:0]   io_in_bits_manager_xact_id;
    logic                  io_in_bits_is_builtin_type;
    logic [P_GTYPE_W-1:0]  io_in_bits_g_type;
    logic [P_DATA_W-1:0]   io_in_bits_data;

    logic                  io_wb_valid;
    logic                  io_wb_ready;
    logic [P_BEAT_W-1:0]   io_wb_bits_addr_beat;
    logic [P_CXID_W-1:0]   io_wb_bits_client_xact_id;
    logic [P_DATA_W-1:0]   io_wb_bits_data;

    logic                  io_finish_valid;
    logic                  io_finish_ready;
    logic [P_MXID_W-1:0]   io_finish_bits_manager_xact_id;

    logic                  io_refill_done;
    logic [P_CXID_W-1:0]   io_refill_done_client_xact_id;
    logic                  io_beat_err;
    logic                  io_busy;

    modport slave (
        input  io_in_valid, io_in_bits_addr_beat, io_in_bits_client_xact_id,
               io_in_bits_manager_xact_id, io_in_bits_is_builtin_type,
               io_in_bits_g_type, io_in_bits_data, io_wb_ready, io_finish_ready,
        output io_in_ready, io_wb_valid, io_wb_bits_addr_beat, io_wb_bits_client_xact_id,
               io_wb_bits_data, io_finish_valid, io_finish_bits_manager_xact_id,
               io_refill_done, io_refill_done_client_xact_id, io_beat_err, io_busy
    );

    modport master (
        output io_in_valid, io_in_bits_addr_beat, io_in_bits_client_xact_id,
               io_in_bits_manager_xact_id, io_in_bits_is_builtin_type,
               io_in_bits_g_type, io_in_bits_data, io_wb_ready, io_finish_ready,
        input  io_in_ready, io_wb_valid, io_wb_bits_addr_beat, io_wb_bits_client_xact_id,
               io_wb_bits_data, io_finish_valid, io_finish_bits_manager_xact_id,
               io_refill_done, io_refill_done_client_xact_id, io_beat_err, io_busy
    );

endinterface

// File: rtl/grant_refill_collector_finish_slot.sv
// rtl/grant_refill_collector_finish_slot.sv - one-entry valid/ready register holding the GrantFinish manager id.
module grant_finish_slot #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [ID_W-1:0] load_id,
    input  logic            ready,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // The collector only loads while the slot is empty, so load never races a drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            id    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            id    <= load_id;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/grant_refill_collector.sv
// rtl/grant_refill_collector.sv - steers grant data beats to the refill port, pulses refill_done and issues GrantFinish.
module grant_refill_collector
    import nbdcache_tl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    grant_refill_collector_if.slave  io
);

    state_t             state;
    state_t             state_nxt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [BEAT_W-1:0]  exp_beat;
    logic               hd;
    logic               mb;
    logic               nf;
    logic               fire;
    logic               last;
    logic               fin_load;
    logic               fin_valid;

    assign hd = has_data(io.io_in_bits_is_builtin_type, io.io_in_bits_g_type);
    assign mb = multibeat(io.io_in_bits_is_builtin_type, io.io_in_bits_g_type);
    assign nf = needs_finish(io.io_in_bits_is_builtin_type);

    // Dataless grants never wait on the refill port.
    assign io.io_in_ready = (state != ST_FINISH) && (!hd || io.io_wb_ready);
    assign io.io_wb_valid = io.io_in_valid && hd && (state != ST_FINISH);
    assign io.io_wb_bits_addr_beat      = io.io_in_bits_addr_beat;
    assign io.io_wb_bits_client_xact_id = io.io_in_bits_client_xact_id;
    assign io.io_wb_bits_data           = io.io_in_bits_data;

    assign fire     = io.io_in_valid && io.io_in_ready;
    assign last     = !mb || (beat_cnt == BEAT_W'(BEATS - 1));
    assign exp_beat = mb ? beat_cnt : '0;
    assign fin_load = fire && last && nf;

    assign io.io_finish_valid = fin_valid;
    assign io.io_busy         = (state != ST_IDLE) || (beat_cnt != '0);

    grant_finish_slot #(.ID_W(MXID_W)) u_finish_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (fin_load),
        .load_id (io.io_in_bits_manager_xact_id),
        .ready   (io.io_finish_ready),
        .valid   (fin_valid),
        .id      (io.io_finish_bits_manager_xact_id)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (fire) begin
                    if (!last)
                        state_nxt = ST_COLLECT;
                    else if (nf)
                        state_nxt = ST_FINISH;
                    else
                        state_nxt = ST_IDLE;
                end
            end
            ST_FINISH: begin
                if (fin_valid && io.io_finish_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                            <= ST_IDLE;
            beat_cnt                         <= '0;
            io.io_refill_done                <= 1'b0;
            io.io_refill_done_client_xact_id <= '0;
            io.io_beat_err                   <= 1'b0;
        end else begin
            state             <= state_nxt;
            io.io_refill_done <= fire && last;
            if (fire && last)
                io.io_refill_done_client_xact_id <= io.io_in_bits_client_xact_id;
            if (fire && hd && mb)
                beat_cnt <= (beat_cnt == BEAT_W'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
            if (fire && hd && (io.io_in_bits_addr_beat != exp_beat))
                io.io_beat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grant_refill_collector.sv
// tb/tb_grant_refill_collector.sv - scoreboard bench for grant_refill_collector.
module tb_grant_refill_collector;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grant_refill_collector_if io ();

    grant_refill_collector dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        logic [1:0]   beat;
        logic [1:0]   cxid;
        logic [127:0] data;
    } wb_t;

    wb_t        wb_q[$];
    logic [3:0] fin_q[$];
    logic [1:0] done_q[$];
    int         checks = 0;
    int         passes = 0;

    function automatic logic m_has_data(input logic builtin, input logic [3:0] gtype);
        case ({builtin, gtype})
            5'b0_0000, 5'b0_0001, 5'b1_0011, 5'b1_0100: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        wb_t        e;
        logic [3:0] f;
        logic [1:0] d;
        if (!reset) begin
            if (io.io_wb_valid && io.io_wb_ready) begin
                checks++;
                if (wb_q.size() == 0) begin
                    $display("FAIL wb_unexpected: got beat %0d, required no write", io.io_wb_bits_addr_beat);
                end else begin
                    e = wb_q.pop_front();
                    if (io.io_wb_bits_addr_beat !== e.beat || io.io_wb_bits_client_xact_id !== e.cxid ||
                        io.io_wb_bits_data !== e.data)
                        $display("FAIL wb_write: got beat %0d cxid %0d data %h, required beat %0d cxid %0d data %h",
                                 io.io_wb_bits_addr_beat, io.io_wb_bits_client_xact_id, io.io_wb_bits_data,
                                 e.beat, e.cxid, e.data);
                    else
                        passes++;
                end
            end
            if (io.io_finish_valid && io.io_finish_ready) begin
                checks++;
                if (fin_q.size() == 0) begin
                    $display("FAIL finish_unexpected: got id %0d, required no finish", io.io_finish_bits_manager_xact_id);
                end else begin
                    f = fin_q.pop_front();
                    if (io.io_finish_bits_manager_xact_id !== f)
                        $display("FAIL finish_id: got %0d required %0d", io.io_finish_bits_manager_xact_id, f);
                    else
                        passes++;
                end
            end
            if (io.io_refill_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    $display("FAIL done_unexpected: got cxid %0d, required no pulse", io.io_refill_done_client_xact_id);
                end else begin
                    d = done_q.pop_front();
                    if (io.io_refill_done_client_xact_id !== d)
                        $display("FAIL done_cxid: got %0d required %0d", io.io_refill_done_client_xact_id, d);
                    else
                        passes++;
                end
            end
        end
    end

    task automatic drive_beat(input logic [1:0] beat, input logic [1:0] cxid, input logic [3:0] mxid,
                              input logic builtin, input logic [3:0] gtype, input logic last);
        logic [127:0] d;
        wb_t          e;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        io.io_in_valid                = 1'b1;
        io.io_in_bits_addr_beat       = beat;
        io.io_in_bits_client_xact_id  = cxid;
        io.io_in_bits_manager_xact_id = mxid;
        io.io_in_bits_is_builtin_type = builtin;
        io.io_in_bits_g_type          = gtype;
        io.io_in_bits_data            = d;
        if (m_has_data(builtin, gtype)) begin
            e.beat = beat; e.cxid = cxid; e.data = d;
            wb_q.push_back(e);
        end
        if (last) begin
            done_q.push_back(cxid);
            if (!builtin) fin_q.push_back(mxid);
        end
    endtask

    task automatic wait_fire(input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (io.io_in_ready) break;
            n++;
            if (n >= 50) begin
                checks++;
                $display("FAIL %s_timeout: got in_ready 0 for %0d cycles, required 1", name, n);
                break;
            end
        end
        @(posedge clk); #1;
        io.io_in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] beat, input logic [1:0] cxid, input logic [3:0] mxid,
                        input logic builtin, input logic [3:0] gtype, input logic last);
        drive_beat(beat, cxid, mxid, builtin, gtype, last);
        wait_fire("send");
        if (last) begin
            checks++;
            if (io.io_refill_done !== 1'b1 || io.io_refill_done_client_xact_id !== cxid)
                $display("FAIL done_timing: got done %b cxid %0d, required 1 cxid %0d",
                         io.io_refill_done, io.io_refill_done_client_xact_id, cxid);
            else passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io.io_in_valid = 1'b0; io.io_in_bits_addr_beat = '0; io.io_in_bits_client_xact_id = '0;
        io.io_in_bits_manager_xact_id = '0; io.io_in_bits_is_builtin_type = 1'b0;
        io.io_in_bits_g_type = '0; io.io_in_bits_data = '0;
        io.io_wb_ready = 1'b1; io.io_finish_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({io.io_finish_valid, io.io_refill_done, io.io_beat_err, io.io_busy} !== 4'b0)
            $display("FAIL reset_flags: got %b required 0000",
                     {io.io_finish_valid, io.io_refill_done, io.io_beat_err, io.io_busy});
        else passes++;
        checks++;
        if (io.io_finish_bits_manager_xact_id !== 4'd0 || io.io_refill_done_client_xact_id !== 2'd0)
            $display("FAIL reset_ids: got fin %0d done %0d required 0 0",
                     io.io_finish_bits_manager_xact_id, io.io_refill_done_client_xact_id);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_multibeat();
        for (int i = 0; i < 4; i++) send(2'(i), 2'd2, 4'd5, 1'b0, 4'd1, i == 3);
        checks++;
        if (io.io_finish_valid !== 1'b1 || io.io_finish_bits_manager_xact_id !== 4'd5)
            $display("FAIL t1_finish: got valid %b id %0d required 1 5", io.io_finish_valid, io.io_finish_bits_manager_xact_id);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (io.io_finish_valid !== 1'b0 || io.io_busy !== 1'b0 || io.io_refill_done !== 1'b0)
            $display("FAIL t1_idle: got fin %b busy %b done %b required 000", io.io_finish_valid, io.io_busy, io.io_refill_done);
        else passes++;
    endtask

    task automatic test_finish_backpressure();
        io.io_finish_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 2'd1, 4'd6, 1'b0, 4'd0, i == 3);
        drive_beat(2'd0, 2'd3, 4'd0, 1'b1, 4'd3, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (io.io_in_ready !== 1'b0 || io.io_finish_valid !== 1'b1 || io.io_finish_bits_manager_xact_id !== 4'd6)
                $display("FAIL t2_hold: got ready %b fin %b id %0d required 0 1 6",
                         io.io_in_ready, io.io_finish_valid, io.io_finish_bits_manager_xact_id);
            else passes++;
        end
        @(posedge clk); #1;
        io.io_finish_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (io.io_in_ready !== 1'b0) $display("FAIL t2_no_bypass: got in_ready %b required 0", io.io_in_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (io.io_in_ready !== 1'b1) $display("FAIL t2_reopen: got in_ready %b required 1", io.io_in_ready);
        else passes++;
        @(posedge clk); #1;
        io.io_in_valid = 1'b0;
        checks++;
        if (io.io_refill_done !== 1'b1 || io.io_refill_done_client_xact_id !== 2'd3 || io.io_finish_valid !== 1'b0)
            $display("FAIL t2_builtin: got done %b cxid %0d fin %b required 1 3 0",
                     io.io_refill_done, io.io_refill_done_client_xact_id, io.io_finish_valid);
        else passes++;
    endtask

    task automatic test_wb_stall();
        send(2'd0, 2'd0, 4'd7, 1'b0, 4'd1, 1'b0);
        send(2'd1, 2'd0, 4'd7, 1'b0, 4'd1, 1'b0);
        drive_beat(2'd2, 2'd0, 4'd7, 1'b0, 4'd1, 1'b0);
        io.io_wb_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (io.io_in_ready !== 1'b0 || io.io_busy !== 1'b1)
                $display("FAIL t3_stall: got in_ready %b busy %b required 0 1", io.io_in_ready, io.io_busy);
            else passes++;
        end
        @(posedge clk); #1;
        io.io_wb_ready = 1'b1;
        wait_fire("t3");
        send(2'd3, 2'd0, 4'd7, 1'b0, 4'd1, 1'b1);
        checks++;
        if (io.io_beat_err !== 1'b0 || io.io_finish_bits_manager_xact_id !== 4'd7)
            $display("FAIL t3_end: got err %b id %0d required 0 7", io.io_beat_err, io.io_finish_bits_manager_xact_id);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_dataless();
        drive_beat(2'd0, 2'd1, 4'd9, 1'b0, 4'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (io.io_wb_valid !== 1'b0 || io.io_in_ready !== 1'b1)
            $display("FAIL t4_nowb: got wb_valid %b in_ready %b required 0 1", io.io_wb_valid, io.io_in_ready);
        else passes++;
        @(posedge clk); #1;
        io.io_in_valid = 1'b0;
        checks++;
        if (io.io_refill_done !== 1'b1 || io.io_refill_done_client_xact_id !== 2'd1 ||
            io.io_finish_valid !== 1'b1 || io.io_finish_bits_manager_xact_id !== 4'd9)
            $display("FAIL t4_ack: got done %b cxid %0d fin %b id %0d required 1 1 1 9", io.io_refill_done,
                     io.io_refill_done_client_xact_id, io.io_finish_valid, io.io_finish_bits_manager_xact_id);
        else passes++;
        @(posedge clk); #1;
        send(2'd0, 2'd3, 4'd0, 1'b1, 4'd3, 1'b1);
        checks++;
        if (io.io_finish_valid !== 1'b0 || io.io_busy !== 1'b0)
            $display("FAIL t4_builtin: got fin %b busy %b required 0 0", io.io_finish_valid, io.io_busy);
        else passes++;
    endtask

    task automatic test_beat_err();
        send(2'd0, 2'd2, 4'd4, 1'b0, 4'd0, 1'b0);
        checks++;
        if (io.io_beat_err !== 1'b0) $display("FAIL t5_clean: got %b required 0", io.io_beat_err);
        else passes++;
        send(2'd2, 2'd2, 4'd4, 1'b0, 4'd0, 1'b0);
        checks++;
        if (io.io_beat_err !== 1'b1) $display("FAIL t5_err: got %b required 1", io.io_beat_err);
        else passes++;
        send(2'd2, 2'd2, 4'd4, 1'b0, 4'd0, 1'b0);
        send(2'd3, 2'd2, 4'd4, 1'b0, 4'd0, 1'b1);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (io.io_beat_err !== 1'b1 || io.io_busy !== 1'b0)
            $display("FAIL t5_sticky: got err %b busy %b required 1 0", io.io_beat_err, io.io_busy);
        else passes++;
    endtask

    task automatic test_async_reset();
        send(2'd0, 2'd1, 4'd2, 1'b0, 4'd1, 1'b0);
        send(2'd1, 2'd1, 4'd2, 1'b0, 4'd1, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({io.io_beat_err, io.io_busy, io.io_refill_done, io.io_finish_valid} !== 4'b0 ||
            io.io_finish_bits_manager_xact_id !== 4'd0 || io.io_refill_done_client_xact_id !== 2'd0)
            $display("FAIL t6_async: got flags %b fin_id %0d done_id %0d required 0000 0 0",
                     {io.io_beat_err, io.io_busy, io.io_refill_done, io.io_finish_valid},
                     io.io_finish_bits_manager_xact_id, io.io_refill_done_client_xact_id);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 2'd3, 4'd10, 1'b0, 4'd1, i == 3);
        checks++;
        if (io.io_beat_err !== 1'b0 || io.io_finish_bits_manager_xact_id !== 4'd10)
            $display("FAIL t6_clean: got err %b id %0d required 0 10", io.io_beat_err, io.io_finish_bits_manager_xact_id);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_multibeat();
        test_finish_backpressure();
        test_wb_stall();
        test_dataless();
        test_beat_err();
        test_async_reset();
        repeat (4) @(posedge clk); #1;
        checks++;
        if (wb_q.size() != 0) $display("FAIL wb_drain: got %0d pending required 0", wb_q.size());
        else passes++;
        checks++;
        if (fin_q.size() != 0) $display("FAIL finish_drain: got %0d pending required 0", fin_q.size());
        else passes++;
        checks++;
        if (done_q.size() != 0) $display("FAIL done_drain: got %0d pending required 0", done_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
